serial_mag_compare: RTL and testbench

- Sequential stage directly downstream of the 2-bit comparator.
- Consumes one 6-bit comparator flag vector per 2-bit digit pair, most-significant digit first, over a valid/ready handshake.
- Folds the digits into one magnitude decision for a 2*DIGITS-bit operand pair.
- Presents the result in the same 6-bit flag encoding through an output valid/ready handshake.

---
 rtl/serial_mag_compare.sv | 213 +++++++++++++++++++++
 tb/tb_serial_mag_compare.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Folds a stream of per-digit comparator flag vectors into one magnitude
//   decision. Digits arrive most-significant first. The first digit that is
//   not EQ decides the result. The result is returned in the same
//   {eq,ne,gt,lt,ge,le} flag encoding.
//
// Optional build macro: COMPARE_EARLY_EXIT_EN
//   When defined, the first deciding digit ends the comparison at once.
//   The digits_used port then reports how many digits were accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle request to begin a comparison (used only in IDLE)
//   in_valid     in_flags holds a digit result
//   in_ready     block accepts a digit this cycle (high only in ACCUM)
//   in_flags     digit flags {eq,ne,gt,lt,ge,le}
//   out_valid    out_flags holds the final result (high only in DONE)
//   out_ready    consumer takes the result this cycle
//   out_flags    final flags {eq,ne,gt,lt,ge,le}
//   busy         high in ACCUM or DONE
//   proto_err    a malformed digit was seen in the current comparison
//   digits_used  (early-exit build only) number of digits accepted
module serial_mag_compare #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_flags,
    output logic       busy,
    output logic       proto_err
`ifdef COMPARE_EARLY_EXIT_EN
    ,
    output logic [CNT_W:0] digits_used
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    // Relation carried by one digit. A malformed digit decodes as EQ.
    function automatic rel_t decode_rel(input logic [5:0] flags);
        case ({flags[5], flags[3], flags[2]})
            3'b100:  decode_rel = REL_EQ;
            3'b010:  decode_rel = REL_GT;
            3'b001:  decode_rel = REL_LT;
            default: decode_rel = REL_EQ;
        endcase
    endfunction

    // A digit is well-formed when exactly one of eq/gt/lt is set.
    function automatic logic is_well_formed(input logic [5:0] flags);
        case ({flags[5], flags[3], flags[2]})
            3'b100, 3'b010, 3'b001: is_well_formed = 1'b1;
            default:                is_well_formed = 1'b0;
        endcase
    endfunction

    // Full six-flag encoding of a relation.
    function automatic logic [5:0] encode_rel(input rel_t rel);
        case (rel)
            REL_EQ:  encode_rel = 6'b100011;
            REL_GT:  encode_rel = 6'b011010;
            REL_LT:  encode_rel = 6'b010101;
            default: encode_rel = 6'b100011;
        endcase
    endfunction

    state_t           state_r, state_nxt_s;
    rel_t             acc_r, acc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [5:0]       out_flags_r, out_flags_nxt_s;
    logic             proto_err_r, proto_err_nxt_s;
    logic             in_ready_r, out_valid_r, busy_r;
    rel_t             dig_rel_s, fold_rel_s;
    logic             unused_flags_s;
`ifdef COMPARE_EARLY_EXIT_EN
    logic [CNT_W:0]   digits_used_r, digits_used_nxt_s;
`endif

    // The ne/ge/le bits repeat the eq/gt/lt information, so the decode ignores them.
    assign unused_flags_s = ^{in_flags[4], in_flags[1], in_flags[0]};

    // Next-state, accumulator and result logic.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        out_flags_nxt_s = out_flags_r;
        proto_err_nxt_s = proto_err_r;
`ifdef COMPARE_EARLY_EXIT_EN
        digits_used_nxt_s = digits_used_r;
`endif
        dig_rel_s  = decode_rel(in_flags);
        // Once acc differs from EQ, a more significant digit has decided the result.
        fold_rel_s = (acc_r == REL_EQ) ? dig_rel_s : acc_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s     = ST_ACCUM;
                    acc_nxt_s       = REL_EQ;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    proto_err_nxt_s = 1'b0;
`ifdef COMPARE_EARLY_EXIT_EN
                    digits_used_nxt_s = {(CNT_W+1){1'b0}};
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_nxt_s = fold_rel_s;
                    if (!is_well_formed(in_flags)) begin
                        proto_err_nxt_s = 1'b1;
                    end else begin
                        proto_err_nxt_s = proto_err_r;
                    end
`ifdef COMPARE_EARLY_EXIT_EN
                    digits_used_nxt_s = {1'b0, cnt_r} + (CNT_W+1)'(1);
`endif
                    // cnt holds on the final accept, so it never wraps.
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s     = ST_DONE;
                        out_flags_nxt_s = encode_rel(fold_rel_s);
                    end
`ifdef COMPARE_EARLY_EXIT_EN
                    else if (fold_rel_s != REL_EQ) begin
                        state_nxt_s     = ST_DONE;
                        out_flags_nxt_s = encode_rel(fold_rel_s);
                    end
`endif
                    else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here, even on the handshake cycle.
                if (out_ready) begin
                    state_nxt_s     = ST_IDLE;
                    out_flags_nxt_s = 6'b000000;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                out_flags_nxt_s = 6'b000000;
            end
        endcase
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= REL_EQ;
            cnt_r       <= {CNT_W{1'b0}};
            out_flags_r <= 6'b000000;
            proto_err_r <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef COMPARE_EARLY_EXIT_EN
            digits_used_r <= {(CNT_W+1){1'b0}};
`endif
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_flags_r <= out_flags_nxt_s;
            proto_err_r <= proto_err_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_ACCUM);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
`ifdef COMPARE_EARLY_EXIT_EN
            digits_used_r <= digits_used_nxt_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_flags = out_flags_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;
`ifdef COMPARE_EARLY_EXIT_EN
    assign digits_used = digits_used_r;
`endif

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare (DIGITS=4).
// The bench pushes expected results to a scoreboard when it drives a
// comparison. It pops and checks them when out_valid rises.
module tb_serial_mag_compare;

    localparam int DIGITS = 4;
    localparam int CNT_W  = 2;
    localparam logic [5:0] F_EQ  = 6'b100011;
    localparam logic [5:0] F_GT  = 6'b011010;
    localparam logic [5:0] F_LT  = 6'b010101;
    localparam logic [5:0] F_BAD = 6'b101000;

    typedef logic [5:0] dig_arr_t [DIGITS];
    typedef struct {
        logic [5:0] flags;
        logic       perr;
        int         used;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, out_ready;
    logic [5:0] in_flags;
    logic in_ready, out_valid, busy, proto_err;
    logic [5:0] out_flags;
`ifdef COMPARE_EARLY_EXIT_EN
    logic [CNT_W:0] digits_used;
`endif

    int vectors = 0;
    int miscompares = 0;
    exp_t sb_q[$];

    serial_mag_compare #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_flags(out_flags),
        .busy(busy), .proto_err(proto_err)
`ifdef COMPARE_EARLY_EXIT_EN
        , .digits_used(digits_used)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the first non-EQ digit (MSB first) decides the result.
    // A malformed digit counts as EQ and flags an error.
    function automatic exp_t model(input dig_arr_t d);
        exp_t e;
        logic [5:0] acc, dr;
        bit stop;
        int n;
        acc = F_EQ; e.perr = 1'b0; e.used = DIGITS; stop = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!stop) begin
                n = int'(d[i][5]) + int'(d[i][3]) + int'(d[i][2]);
                if (n != 1)        begin dr = F_EQ; e.perr = 1'b1; end
                else if (d[i][5])  dr = F_EQ;
                else if (d[i][3])  dr = F_GT;
                else               dr = F_LT;
                if (acc == F_EQ) acc = dr;
`ifdef COMPARE_EARLY_EXIT_EN
                if (acc != F_EQ) begin e.used = i + 1; stop = 1'b1; end
`endif
            end
        end
        e.flags = acc;
        return e;
    endfunction

    // Drive-only helper. It starts a comparison and offers digits until
    // out_valid rises or the cycle budget expires.
    task automatic drive_cmp(input dig_arr_t d, input bit gaps,
                             output bit got, output int edges, output int accepted);
        bit acc_now;
        int slot;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        accepted = 0; edges = 0; slot = 0;
        while (!out_valid && edges < 60) begin
            if (accepted < DIGITS && (!gaps || (slot % 3) == 0)) begin
                in_valid = 1'b1; in_flags = d[accepted];
            end else begin
                in_valid = 1'b0; in_flags = 6'b111111;
            end
            acc_now = in_valid && in_ready;
            @(negedge clk);
            if (acc_now) accepted++;
            edges++; slot++;
        end
        in_valid = 1'b0; in_flags = 6'b000000;
        got = out_valid;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flags = 6'b000000;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_flags, busy, proto_err} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000000000", {in_ready, out_valid, out_flags, busy, proto_err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    // Shared by the scenario tasks. Runs one comparison and checks it inline.
    task automatic test_compare(input string name, input dig_arr_t d, input bit gaps, input bit chk_lat);
        exp_t e;
        bit got;
        int edges, accepted;
        sb_q.push_back(model(d));
        drive_cmp(d, gaps, got, edges, accepted);
        e = sb_q.pop_front();
        vectors++;
        if (got !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: out_valid=%b expected 1", name, got);
        end
        vectors++;
        if (out_flags !== e.flags) begin
            miscompares++;
            $display("FAIL %s_flags: got %b expected %b", name, out_flags, e.flags);
        end
        vectors++;
        if (proto_err !== e.perr) begin
            miscompares++;
            $display("FAIL %s_proto_err: got %b expected %b", name, proto_err, e.perr);
        end
        vectors++;
        if (accepted !== e.used || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_accepted: got %0d in_ready=%b expected %0d in_ready=0", name, accepted, in_ready, e.used);
        end
`ifdef COMPARE_EARLY_EXIT_EN
        vectors++;
        if (digits_used !== (CNT_W+1)'(e.used)) begin
            miscompares++;
            $display("FAIL %s_digits_used: got %0d expected %0d", name, digits_used, e.used);
        end
`endif
        if (chk_lat) begin
            // Counting the start cycle as cycle 1, out_valid is high in cycle used+2.
            vectors++;
            if (edges + 2 !== e.used + 2 || e.used + 2 > DIGITS + 2) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d cycles expected %0d", name, edges + 2, e.used + 2);
            end
        end
        do_handshake();
        vectors++;
        if ({out_valid, out_flags, busy} !== 8'd0) begin
            miscompares++;
            $display("FAIL %s_release: got %b expected 00000000", name, {out_valid, out_flags, busy});
        end
    endtask

    task automatic test_all_eq();
        dig_arr_t d = '{F_EQ, F_EQ, F_EQ, F_EQ};
        test_compare("all_eq", d, 1'b0, 1'b1);
    endtask

    task automatic test_gt_first();
        dig_arr_t d = '{F_EQ, F_GT, F_EQ, F_LT};
        test_compare("gt_first", d, 1'b0, 1'b1);
    endtask

    task automatic test_lt_first();
        dig_arr_t d = '{F_LT, F_GT, F_GT, F_GT};
        test_compare("lt_first", d, 1'b0, 1'b1);
    endtask

    task automatic test_gaps();
        dig_arr_t d = '{F_EQ, F_EQ, F_LT, F_EQ};
        test_compare("gaps", d, 1'b1, 1'b0);
    endtask

    task automatic test_hold();
        dig_arr_t d = '{F_GT, F_EQ, F_EQ, F_EQ};
        exp_t e;
        bit got;
        int edges, accepted;
        sb_q.push_back(model(d));
        drive_cmp(d, 1'b0, got, edges, accepted);
        e = sb_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            start = (c == 1 || c == 3);
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || out_flags !== e.flags || in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_c%0d: valid=%b flags=%b in_ready=%b busy=%b expected 1 %b 0 1", c, out_valid, out_flags, in_ready, busy, e.flags);
            end
        end
        start = 1'b1;
        do_handshake();
        start = 1'b0;
        vectors++;
        if ({out_valid, out_flags, busy} !== 8'd0) begin
            miscompares++;
            $display("FAIL hold_release: got %b expected 00000000", {out_valid, out_flags, busy});
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_start_ignored: busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        dig_arr_t d = '{F_EQ, F_EQ, F_EQ, F_GT};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_flags = F_EQ;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_accum: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_flags, busy, proto_err} !== 10'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got %b expected 0000000000", {in_ready, out_valid, out_flags, busy, proto_err});
        end
        @(negedge clk); rst_n = 1'b1;
        test_compare("after_reset", d, 1'b0, 1'b1);
    endtask

    task automatic test_malformed();
        dig_arr_t d  = '{F_EQ, F_BAD, F_EQ, F_EQ};
        dig_arr_t d2 = '{F_EQ, F_EQ, F_EQ, F_EQ};
        test_compare("malformed", d, 1'b0, 1'b0);
        test_compare("perr_cleared", d2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        dig_arr_t d;
        logic [5:0] pool [5] = '{F_EQ, F_EQ, F_GT, F_LT, F_BAD};
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DIGITS; i++) d[i] = pool[$urandom_range(4, 0)];
            test_compare($sformatf("b2b%0d", t), d, 1'($urandom_range(1, 0)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_all_eq();
        test_gt_first();
        test_lt_first();
        test_hold();
        test_gaps();
        test_mid_reset();
        test_malformed();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
